// File: rtl/day1_line_parser_if.sv
// Byte-stream input and packet/status output bundle for the Day 1 line parser.
interface day1_line_parser_if #(parameter int P_CNT_W = 16);
  logic               i_byteValid;
  logic [7:0]         i_byte;
  logic               i_last;
  logic               o_dataValid;
  logic [31:0]        o_packet;
  logic               o_overflow;
  logic [P_CNT_W-1:0] o_lineCount;
  logic [P_CNT_W-1:0] o_errCount;
  logic               o_done;

  modport master (
    output i_byteValid, i_byte, i_last,
    input  o_dataValid, o_packet, o_overflow, o_lineCount, o_errCount, o_done
  );

  modport slave (
    input  i_byteValid, i_byte, i_last,
    output o_dataValid, o_packet, o_overflow, o_lineCount, o_errCount, o_done
  );
endinterface

// File: rtl/day1_line_parser.sv
// Parses ASCII "L68"/"R48" lines into {dir, val[30:0]} rotation packets,
// saturating magnitudes and counting good and malformed lines.
module day1_line_parser #(
  parameter int P_CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  day1_line_parser_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIR    = 2'd1;
  localparam logic [1:0] S_DIGITS = 2'd2;
  localparam logic [1:0] S_SKIP   = 2'd3;

  localparam logic [7:0] C_L  = 8'h4C;
  localparam logic [7:0] C_R  = 8'h52;
  localparam logic [7:0] C_NL = 8'h0A;
  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_SP = 8'h20;
  localparam logic [34:0] C_MAX = 35'h0_7FFF_FFFF;

  logic [1:0]         state_q, state_d;
  logic               dir_q, dir_d;
  logic [30:0]        acc_q, acc_d;
  logic               sat_q, sat_d;
  logic               dv_q;
  logic [31:0]        pkt_q;
  logic               ovf_q;
  logic [P_CNT_W-1:0] line_q, err_q;
  logic               done_q;

  logic        emit, err_inc;
  logic        is_digit, is_nl, is_ws;
  logic [3:0]  digit;
  logic [34:0] mul;

  assign is_digit = (bus.i_byte >= 8'h30) && (bus.i_byte <= 8'h39);
  assign digit    = bus.i_byte[3:0];
  assign is_nl    = (bus.i_byte == C_NL);
  assign is_ws    = (bus.i_byte == C_CR) || (bus.i_byte == C_SP);
  // 35 bits holds 0x7FFFFFFF*10+9 without wrap, so one compare detects overflow.
  assign mul      = ({4'd0, acc_q} * 35'd10) + {31'd0, digit};

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    emit    = 1'b0;
    err_inc = 1'b0;
    if (bus.i_byteValid) begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_byte == C_L || bus.i_byte == C_R) begin
            dir_d   = (bus.i_byte == C_R);
            acc_d   = '0;
            sat_d   = 1'b0;
            state_d = S_DIR;
          end else if (!(is_nl || is_ws)) begin
            err_inc = 1'b1;
            state_d = S_SKIP;
          end
        end
        S_DIR: begin
          if (is_digit) begin
            acc_d   = {27'd0, digit};
            state_d = S_DIGITS;
          end else if (is_nl) begin
            err_inc = 1'b1;
            state_d = S_IDLE;
          end else if (!is_ws) begin
            err_inc = 1'b1;
            state_d = S_SKIP;
          end
        end
        S_DIGITS: begin
          if (is_digit) begin
            if (mul > C_MAX) begin
              acc_d = 31'h7FFF_FFFF;
              sat_d = 1'b1;
            end else begin
              acc_d = mul[30:0];
            end
          end else if (is_nl) begin
            emit    = 1'b1;
            state_d = S_IDLE;
          end else if (!is_ws) begin
            err_inc = 1'b1;
            state_d = S_SKIP;
          end
        end
        default: if (is_nl) state_d = S_IDLE;
      endcase
      // End of file acts as an implicit newline applied after the byte itself.
      if (bus.i_last) begin
        if (state_d == S_DIGITS) emit = 1'b1;
        if (state_d == S_DIR)    err_inc = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      dv_q    <= 1'b0;
      pkt_q   <= '0;
      ovf_q   <= 1'b0;
      line_q  <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      dv_q    <= emit;
      ovf_q   <= ovf_q | sat_d;
      if (emit) begin
        pkt_q  <= {dir_d, acc_d};
        line_q <= line_q + 1'b1;
      end
      if (err_inc) err_q <= err_q + 1'b1;
      if (bus.i_byteValid && bus.i_last) done_q <= 1'b1;
    end
  end

  assign bus.o_dataValid = dv_q;
  assign bus.o_packet    = pkt_q;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_lineCount = line_q;
  assign bus.o_errCount  = err_q;
  assign bus.o_done      = done_q;
endmodule

// File: tb/tb_day1_line_parser.sv
// Scoreboard bench for day1_line_parser: expected packets queued as lines are sent.
module tb_day1_line_parser;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   exp_lines = 0;
  int   exp_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  day1_line_parser_if #(.P_CNT_W(16)) bus();
  day1_line_parser #(.P_CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always @(negedge clk)
    if (bus.o_dataValid === 1'b1) got_q.push_back(bus.o_packet);

  task automatic send_byte(input logic [7:0] b, input bit last);
    bus.i_byteValid = 1'b1;
    bus.i_byte      = b;
    bus.i_last      = last;
    @(posedge clk); #1;
  endtask

  task automatic send_str(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], last && (i == s.len() - 1));
  endtask

  task automatic idle();
    bus.i_byteValid = 1'b0;
    bus.i_last      = 1'b0;
    bus.i_byte      = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    repeat (2) @(posedge clk); #1;
    tests++; if (bus.o_dataValid !== 1'b0) begin fails++; $display("FAIL reset_dv: got %b exp 0", bus.o_dataValid); end
    tests++; if (bus.o_packet !== 32'h0) begin fails++; $display("FAIL reset_pkt: got %h exp 0", bus.o_packet); end
    tests++; if (bus.o_overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b exp 0", bus.o_overflow); end
    tests++; if (bus.o_lineCount !== 16'h0) begin fails++; $display("FAIL reset_lines: got %0d exp 0", bus.o_lineCount); end
    tests++; if (bus.o_errCount !== 16'h0) begin fails++; $display("FAIL reset_err: got %0d exp 0", bus.o_errCount); end
    tests++; if (bus.o_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b exp 0", bus.o_done); end
    rst = 1'b0;
    exp_lines = 0; exp_err = 0;
  endtask

  task automatic test_basic();
    exp_q.push_back(32'h0000_0044); exp_lines++;
    send_str("L68\n", 1'b0);
    tests++; if (bus.o_dataValid !== 1'b1) begin fails++; $display("FAIL basic_latency: got dv=%b exp 1", bus.o_dataValid); end
    tests++; if (bus.o_packet !== 32'h0000_0044) begin fails++; $display("FAIL basic_pkt: got %h exp 00000044", bus.o_packet); end
    tests++; if (bus.o_lineCount !== 16'(exp_lines)) begin fails++; $display("FAIL basic_lines: got %0d exp %0d", bus.o_lineCount, exp_lines); end
    idle(); @(posedge clk); #1;
    tests++; if (bus.o_dataValid !== 1'b0) begin fails++; $display("FAIL basic_pulse: got dv=%b exp 0", bus.o_dataValid); end
    repeat (2) @(posedge clk); #1;
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL basic_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g; e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL basic_sb: got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_blank();
    exp_q.push_back(32'h8000_0030); exp_q.push_back(32'h0000_0005); exp_lines += 2;
    send_str("R48\r\n\n\nL5\n", 1'b0);
    idle(); repeat (3) @(posedge clk); #1;
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL blank_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g; e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL blank_sb: got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    tests++; if (bus.o_lineCount !== 16'(exp_lines)) begin fails++; $display("FAIL blank_lines: got %0d exp %0d", bus.o_lineCount, exp_lines); end
    tests++; if (bus.o_errCount !== 16'(exp_err)) begin fails++; $display("FAIL blank_err: got %0d exp %0d", bus.o_errCount, exp_err); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      bit d = 1'($urandom_range(0, 1));
      int unsigned v = $urandom_range(0, 99999);
      exp_q.push_back({d, 31'(v)}); exp_lines++;
      send_str($sformatf("%s%0d\n", d ? "R" : "L", v), 1'b0);
    end
    exp_q.push_back(32'hFFFF_FFFF); exp_lines++;
    send_str("R2147483647\n", 1'b0);
    exp_q.push_back(32'h8000_0009); exp_lines++;
    send_str("R9\n", 1'b0);
    idle(); repeat (3) @(posedge clk); #1;
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g; e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL b2b_sb: got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    tests++; if (bus.o_overflow !== 1'b0) begin fails++; $display("FAIL b2b_max_no_ovf: got %b exp 0", bus.o_overflow); end
    tests++; if (bus.o_lineCount !== 16'(exp_lines)) begin fails++; $display("FAIL b2b_lines: got %0d exp %0d", bus.o_lineCount, exp_lines); end
  endtask

  task automatic test_overflow();
    exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'h0000_0001); exp_lines += 2;
    send_str("R2147483648\n", 1'b0);
    tests++; if (bus.o_overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b exp 1", bus.o_overflow); end
    send_str("L1\n", 1'b0);
    idle(); repeat (3) @(posedge clk); #1;
    tests++; if (bus.o_overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b exp 1", bus.o_overflow); end
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL ovf_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g; e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL ovf_sb: got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_errors();
    exp_q.push_back(32'h8000_0009); exp_lines++; exp_err += 2;
    send_str("X12\n", 1'b0);
    tests++; if (bus.o_errCount !== 16'(exp_err - 1)) begin fails++; $display("FAIL err_first: got %0d exp %0d", bus.o_errCount, exp_err - 1); end
    send_str("L\nR9\n", 1'b0);
    idle(); repeat (3) @(posedge clk); #1;
    tests++; if (bus.o_errCount !== 16'(exp_err)) begin fails++; $display("FAIL err_count: got %0d exp %0d", bus.o_errCount, exp_err); end
    tests++; if (bus.o_lineCount !== 16'(exp_lines)) begin fails++; $display("FAIL err_lines: got %0d exp %0d", bus.o_lineCount, exp_lines); end
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL err_pktcount: got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g; e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL err_sb: got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midline();
    send_str("R12", 1'b0);
    idle(); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; exp_lines = 0; exp_err = 0;
    tests++; if ({bus.o_dataValid, bus.o_overflow, bus.o_done} !== 3'b000 || bus.o_packet !== 32'h0 ||
                 bus.o_lineCount !== 16'h0 || bus.o_errCount !== 16'h0) begin
      fails++; $display("FAIL midreset_zero: got dv=%b pkt=%h ovf=%b lines=%0d err=%0d done=%b exp all 0",
                        bus.o_dataValid, bus.o_packet, bus.o_overflow, bus.o_lineCount, bus.o_errCount, bus.o_done);
    end
    exp_err = 1;
    send_str("3\n", 1'b0);
    idle(); repeat (3) @(posedge clk); #1;
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL midreset_nopkt: got %0d exp 0", got_q.size()); end
    tests++; if (bus.o_errCount !== 16'(exp_err)) begin fails++; $display("FAIL midreset_err: got %0d exp %0d", bus.o_errCount, exp_err); end
    tests++; if (bus.o_lineCount !== 16'h0) begin fails++; $display("FAIL midreset_lines: got %0d exp 0", bus.o_lineCount); end
    got_q.delete();
  endtask

  task automatic test_last();
    exp_q.push_back(32'h0000_0007); exp_lines++;
    send_str("L7", 1'b1);
    tests++; if (bus.o_dataValid !== 1'b1 || bus.o_done !== 1'b1) begin fails++; $display("FAIL last_dv_done: got dv=%b done=%b exp 1 1", bus.o_dataValid, bus.o_done); end
    tests++; if (bus.o_packet !== 32'h0000_0007) begin fails++; $display("FAIL last_pkt: got %h exp 00000007", bus.o_packet); end
    exp_q.push_back(32'h8000_0007); exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_0005); exp_lines += 3;
    send_str("R007\nL0\n", 1'b0);
    send_str("L5\n", 1'b1);
    exp_err++;
    send_str("R", 1'b1);
    idle(); repeat (3) @(posedge clk); #1;
    tests++; if (bus.o_done !== 1'b1) begin fails++; $display("FAIL last_done_sticky: got %b exp 1", bus.o_done); end
    tests++; if (bus.o_errCount !== 16'(exp_err)) begin fails++; $display("FAIL last_dir_err: got %0d exp %0d", bus.o_errCount, exp_err); end
    tests++; if (bus.o_lineCount !== 16'(exp_lines)) begin fails++; $display("FAIL last_lines: got %0d exp %0d", bus.o_lineCount, exp_lines); end
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL last_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g; e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL last_sb: got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_blank();
    test_back_to_back();
    test_overflow();
    test_errors();
    test_reset_midline();
    test_last();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
